// File: rtl/coproc_pkg.sv
// Shared sizing constants for the coprocessor result FIFO.
// DEPTH must be a power of two so pointers wrap naturally.
package coproc_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchronizer with edge register; one-cycle pulse per rising edge.
// A level already high when reset releases is ignored until it drops.
module sync_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

    logic       sync1;
    logic       sync2;
    logic       sync3;
    logic       armed;
    logic [1:0] prime;

    // prime marks when sync2 first holds a genuine post-reset sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            prime <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
            sync3 <= sync2;
            prime <= {prime[0], 1'b1};
            if (prime[1] && !sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = sync2 & ~sync3 & armed;

endmodule

// File: rtl/coproc_result_fifo.sv
// Result FIFO between a coprocessor stream and HPS PIO pop/clear strobes.
// Pop and clear arrive as asynchronous levels and act on their rising edges.
module coproc_result_fifo #(
    parameter int DATA_W = coproc_pkg::DATA_W,
    parameter int DEPTH  = coproc_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       res_valid,
    input  logic [DATA_W-1:0]          res_data,
    output logic                       res_ready,
    input  logic                       pop_req,
    input  logic                       clr_req,
    output logic [DATA_W-1:0]          dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              pop_pulse;
    logic              clr_pulse;
    logic              wr_en;
    logic              rd_en;

    sync_rise u_pop_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pop_req),
        .pulse   (pop_pulse)
    );

    sync_rise u_clr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (clr_req),
        .pulse   (clr_pulse)
    );

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign res_ready = ~full;
    assign wr_en     = res_valid & ~full;
    assign rd_en     = pop_pulse & ~empty;
    assign dout      = empty ? '0 : mem[rd_ptr];

    // clear outranks every same-cycle write, pop and overflow event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr_pulse) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (res_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr_pulse) begin
            mem[wr_ptr] <= res_data;
        end
    end

endmodule

// File: tb/tb_coproc_result_fifo.sv
// Randomized and directed bench for coproc_result_fifo.
// A queue model tracks contents; strobe events come from sampled level history.
module tb_coproc_result_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       res_valid = 1'b0;
    logic [7:0] res_data = 8'h00;
    logic       res_ready;
    logic       pop_req = 1'b0;
    logic       clr_req = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    coproc_result_fifo dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .pop_req   (pop_req),
        .clr_req   (clr_req),
        .dout      (dout),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Model: queue of stored bytes, sticky overflow, and sampled strobe
    // levels (p1 = last edge, p2 = two edges ago, p3 = three edges ago).
    // A strobe acts at edge e when it was sampled 0 at e-3 and 1 at e-2;
    // the level before reset release is treated as high.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;
    logic       c1 = 1'b1, c2 = 1'b1, c3 = 1'b1;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                q.delete();
                m_ovf = 1'b0;
                p1 = 1'b1; p2 = 1'b1; p3 = 1'b1;
                c1 = 1'b1; c2 = 1'b1; c3 = 1'b1;
            end else begin
                logic pop_ev, clr_ev, was_full, was_empty;
                pop_ev    = p2 && !p3;
                clr_ev    = c2 && !c3;
                was_full  = (q.size() == DEPTH);
                was_empty = (q.size() == 0);
                p3 = p2; p2 = p1; p1 = pop_req;
                c3 = c2; c2 = c1; c1 = clr_req;
                if (clr_ev) begin
                    q.delete();
                    m_ovf = 1'b0;
                end else begin
                    if (pop_ev && !was_empty) void'(q.pop_front());
                    if (res_valid && !was_full) q.push_back(res_data);
                    if (res_valid && was_full) m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("m_count", int'(count), q.size());
            chk("m_dout", int'(dout), (q.size() > 0) ? int'(q[0]) : 0);
            chk("m_empty", int'(empty), int'(q.size() == 0));
            chk("m_full", int'(full), int'(q.size() == DEPTH));
            chk("m_ready", int'(res_ready), int'(q.size() != DEPTH));
            chk("m_ovf", int'(overflow), int'(m_ovf));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        res_valid = 1'b1;
        res_data  = b;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        pop_req = 1'b1;
        idle(4);
        pop_req = 1'b0;
        idle(4);
    endtask

    task automatic clr_one();
        @(negedge clk);
        clr_req = 1'b1;
        idle(4);
        clr_req = 1'b0;
        idle(4);
    endtask

    // raise a strobe and present a result on the edge where it acts
    task automatic strobe_with_write(input bit is_clr, input logic [7:0] b);
        @(negedge clk);
        if (is_clr) clr_req = 1'b1;
        else        pop_req = 1'b1;
        idle(2);
        res_valid = 1'b1;
        res_data  = b;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic drop_strobes();
        pop_req = 1'b0;
        clr_req = 1'b0;
        idle(4);
    endtask

    initial begin
        idle(3);
        reset_n = 1'b1;
        idle(5);
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_dout", int'(dout), 8'h00);
        chk("rst_ready", int'(res_ready), 1);
        chk("rst_ovf", int'(overflow), 0);

        write_byte(8'hA5);
        chk("first_dout", int'(dout), 8'hA5);
        write_byte(8'h3C);
        @(negedge clk);
        pop_req = 1'b1;
        @(negedge clk);
        chk("pop_lat_k", int'(count), 2);
        @(negedge clk);
        chk("pop_lat_k1", int'(count), 2);
        @(negedge clk);
        chk("pop_lat_k2_cnt", int'(count), 1);
        chk("pop_lat_k2_dout", int'(dout), 8'h3C);
        pop_req = 1'b0;
        idle(4);
        pop_one();
        chk("drain_empty", int'(empty), 1);

        for (int i = 0; i < 16; i++) write_byte(8'(i));
        write_byte(8'hFF);
        chk("fill_full", int'(full), 1);
        chk("fill_ready", int'(res_ready), 0);
        chk("fill_ovf", int'(overflow), 1);
        chk("fill_count", int'(count), 16);
        for (int i = 0; i < 16; i++) begin
            chk("order_dout", int'(dout), i);
            pop_one();
        end
        chk("order_empty", int'(empty), 1);

        clr_one();
        for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
        strobe_with_write(1'b0, 8'h77);
        chk("full_coinc_cnt", int'(count), 15);
        chk("full_coinc_ovf", int'(overflow), 1);
        drop_strobes();
        clr_one();
        strobe_with_write(1'b0, 8'h5A);
        chk("empty_coinc_cnt", int'(count), 1);
        chk("empty_coinc_dout", int'(dout), 8'h5A);
        drop_strobes();
        clr_one();

        for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i));
        @(negedge clk);
        pop_req = 1'b1;
        idle(10);
        pop_req = 1'b0;
        idle(2);
        chk("hold_count", int'(count), 4);
        chk("hold_dout", int'(dout), 8'h11);
        clr_one();

        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < 4; i++) write_byte(8'(8'h80 + b * 4 + i));
            for (int i = 0; i < 4; i++) begin
                chk("wrap_dout", int'(dout), 8'h80 + b * 4 + i);
                pop_one();
            end
        end
        chk("wrap_empty", int'(empty), 1);

        for (int i = 0; i < 17; i++) write_byte(8'(8'hC0 + i));
        for (int i = 0; i < 9; i++) pop_one();
        chk("pre_clr_count", int'(count), 7);
        chk("pre_clr_ovf", int'(overflow), 1);
        strobe_with_write(1'b1, 8'hEE);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_dout", int'(dout), 8'h00);
        drop_strobes();

        for (int i = 0; i < 9; i++) write_byte(8'(i + 1));
        chk("pre_rst_count", int'(count), 9);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async_rst_count", int'(count), 0);
        chk("async_rst_empty", int'(empty), 1);
        #1 reset_n = 1'b1;
        idle(4);

        @(negedge clk);
        pop_req = 1'b1;
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        write_byte(8'h21);
        write_byte(8'h22);
        idle(10);
        chk("high_at_release", int'(count), 2);
        pop_req = 1'b0;
        idle(4);
        pop_one();
        chk("rearm_pop", int'(count), 1);
        chk("rearm_dout", int'(dout), 8'h22);

        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            res_valid = ($urandom_range(0, 99) < (((i / 250) % 2 == 0) ? 85 : 15));
            res_data  = 8'($urandom);
            if ($urandom_range(0, 2) == 0) pop_req = ~pop_req;
            if ($urandom_range(0, 80) == 0) clr_req = ~clr_req;
        end
        res_valid = 1'b0;
        drop_strobes();
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coproc_result_fifo.md
COPROC_RESULT_FIFO -- requirements
Module: coproc_result_fifo

Interface
REQ-001 Parameter DATA_W SHALL default 8; it is the result byte width.
REQ-002 Parameter DEPTH SHALL default 16; it is the FIFO entry count, a power of two, at least 2.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 res_valid  input  1  coprocessor result valid.
REQ-006 res_data  input  DATA_W  coprocessor result byte.
REQ-007 res_ready  output  1  FIFO can accept a result.
REQ-008 pop_req  input  1  HPS PIO level; a rising edge requests one pop; asynchronous to clk.
REQ-009 clr_req  input  1  HPS PIO level; a rising edge flushes the FIFO; asynchronous to clk.
REQ-010 dout  output  DATA_W  head entry; drives the PIO data-in port.
REQ-011 empty  output  1  FIFO holds 0 entries.
REQ-012 full  output  1  FIFO holds DEPTH entries.
REQ-013 count  output  log2(DEPTH)+1  current occupancy.
REQ-014 overflow  output  1  sticky flag: a result was dropped.

Function
REQ-015 res_ready SHALL equal NOT full, combinationally.
REQ-016 A write SHALL occur on a rising clk edge where res_valid=1 and full=0: res_data is stored at wr_ptr, wr_ptr increments modulo DEPTH, and count increments.
REQ-017 pop_req and clr_req SHALL each pass through a 2-FF synchronizer plus a third register; the event pulse is sync2 AND NOT sync3, lasting exactly 1 cycle per rising edge.
REQ-018 Pop latency: if pop_req rises before edge k, rd_ptr and count SHALL update at edge k+2; holding pop_req high SHALL produce no further pops.
REQ-019 A pop pulse SHALL be ignored when empty=1; rd_ptr and count are unchanged.
REQ-020 dout SHALL equal mem[rd_ptr] when empty=0, and 0 when empty=1.
REQ-021 A write and a pop in the same cycle with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-022 When count=DEPTH, a write and a pop in the same cycle SHALL perform only the pop; the write is rejected because res_ready=0.
REQ-023 When count=0, a write and a pop in the same cycle SHALL perform only the write.
REQ-024 overflow SHALL set on any edge where res_valid=1 and full=1, and SHALL stay set until a clear pulse.
REQ-025 A clear pulse SHALL zero wr_ptr, rd_ptr, count and overflow, and SHALL take priority over a same-cycle write, pop or overflow event.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0; empty and full SHALL be decoded from count.
REQ-027 Memory contents SHALL NOT need reset.

Reset
REQ-028 On reset_n=0, asynchronously: pointers=0, count=0, overflow=0, all synchronizer registers=0; resulting outputs dout=0, empty=1, full=0, res_ready=1.
REQ-029 A pop_req or clr_req level that is already high when reset releases SHALL NOT generate a pulse until it goes low and then high again.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries and any in-flight synchronizer pulse.

Structure
REQ-031 Shared package coproc_pkg SHALL hold DATA_W, DEPTH, PTR_W=log2(DEPTH) and CNT_W=PTR_W+1.
REQ-032 One sub-module, sync_rise, SHALL implement the 2-FF synchronizer, edge register and pulse output; it is instantiated twice, for pop_req and clr_req.

Verification
REQ-033 Reset release with no stimulus -> empty=1, count=0, dout=0x00, res_ready=1, overflow=0.
REQ-034 Write 0xA5, then 0x3C, then raise pop_req -> dout=0xA5 immediately after the first write; dout=0x3C and count=1 exactly 2 edges after the first edge that samples pop_req high.
REQ-035 Write 16 bytes 0x00..0x0F, then a 17th byte 0xFF -> full=1, res_ready=0, overflow=1, count=16; popping all 16 returns 0x00..0x0F in order with 0xFF absent.
REQ-036 With count=16, drive res_valid=1 on the same edge as a pop pulse -> count=15 and overflow=1; with count=0, the same coincidence -> count=1 and dout=the written byte.
REQ-037 Hold pop_req high for 10 cycles with count=5 -> count=4, exactly one pop; after pointer wrap (write 20, pop 20 in interleaved bursts) -> data order preserved and empty=1.
REQ-038 Raise clr_req on the same cycle as res_valid=1 with count=7 and overflow=1 -> count=0, empty=1, overflow=0, dout=0x00; reset_n pulsed low with count=9 -> count=0 asynchronously.
